// File: rtl/hilbert_spectral_mask.sv
// Hilbert / analytic-signal spectral weighting applied per FFT bin index.
// Two-stage elastic pipeline with SOF-based frame alignment; multiplier-free.
module hilbert_spectral_mask #(
   parameter int N = 4,
   parameter int W = 21
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_re,
   input  logic [W-1:0] in_im,
   input  logic         in_valid,
   input  logic         in_sof,
   output logic         in_ready,
   input  logic         mode,
   output logic [W-1:0] out_re,
   output logic [W-1:0] out_im,
   output logic         out_valid,
   output logic         out_sof,
   input  logic         out_ready,
   output logic         frame_err
);
   localparam int KW = $clog2(N);
   localparam logic [KW-1:0] HALF = KW'(N / 2);
   localparam logic [W-1:0]  SMAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]  SMIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic {UNSYNC, SYNC} state_t;

   state_t        state;
   logic [KW-1:0] k;
   logic          cur_mode;

   logic          s1_full;
   logic          s1_mode;
   logic [KW-1:0] s1_k;
   logic [W-1:0]  s1_re;
   logic [W-1:0]  s1_im;

   logic          s2_ready;
   logic          acc;
   logic          take;
   logic          misalign;
   logic [KW-1:0] bin;
   logic          bin_mode;
   logic [W-1:0]  w_re;
   logic [W-1:0]  w_im;

   function automatic logic [W-1:0] sat_neg(input logic [W-1:0] x);
      return (x == SMIN) ? SMAX : ('0 - x);
   endfunction

   // Doubling overflows exactly when the two top bits differ.
   function automatic logic [W-1:0] sat_dbl(input logic [W-1:0] x);
      if (x[W-1] != x[W-2])
         return x[W-1] ? SMIN : SMAX;
      return {x[W-2:0], 1'b0};
   endfunction

   always_comb begin
      s2_ready = !out_valid || out_ready;
      in_ready = !s1_full || s2_ready;
      acc      = in_valid && in_ready;
      take     = acc && (state == SYNC || in_sof);
      misalign = acc && in_sof && (state == SYNC) && (k != '0);
      bin      = in_sof ? '0 : k;
      bin_mode = in_sof ? mode : cur_mode;
   end

   always_comb begin
      w_re = '0;
      w_im = '0;
      if (!s1_mode) begin
         if (s1_k != '0 && s1_k != HALF) begin
            if (s1_k < HALF) begin
               w_re = s1_im;
               w_im = sat_neg(s1_re);
            end else begin
               w_re = sat_neg(s1_im);
               w_im = s1_re;
            end
         end
      end else if (s1_k == '0 || s1_k == HALF) begin
         w_re = s1_re;
         w_im = s1_im;
      end else if (s1_k < HALF) begin
         w_re = sat_dbl(s1_re);
         w_im = sat_dbl(s1_im);
      end
   end

   // Frame alignment: UNSYNC discards until an SOF; any SOF restarts k at 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= UNSYNC;
         k         <= '0;
         cur_mode  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= misalign;
         if (take) begin
            state    <= SYNC;
            k        <= bin + KW'(1);
            cur_mode <= bin_mode;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_full <= 1'b0;
         s1_mode <= 1'b0;
         s1_k    <= '0;
         s1_re   <= '0;
         s1_im   <= '0;
      end else if (take) begin
         s1_full <= 1'b1;
         s1_mode <= bin_mode;
         s1_k    <= bin;
         s1_re   <= in_re;
         s1_im   <= in_im;
      end else if (s2_ready) begin
         s1_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_sof   <= 1'b0;
      end else if (s2_ready) begin
         out_valid <= s1_full;
         if (s1_full) begin
            out_re  <= w_re;
            out_im  <= w_im;
            out_sof <= (s1_k == '0);
         end
      end
   end

endmodule

// File: tb/tb_hilbert_spectral_mask.sv
// Self-checking bench for hilbert_spectral_mask: directed frames plus randomized
// backpressure traffic checked against an arithmetic reference model.
module tb_hilbert_spectral_mask;
   localparam int     N   = 4;
   localparam int     W   = 21;
   localparam int     Q   = 1024;
   localparam longint LIM = longint'(1) << (W - 1);

   typedef struct packed {
      logic         sof;
      logic [W-1:0] re;
      logic [W-1:0] im;
   } bin_t;

   logic         clk;
   logic         rst;
   logic [W-1:0] in_re;
   logic [W-1:0] in_im;
   logic         in_valid;
   logic         in_sof;
   logic         in_ready;
   logic         mode;
   logic [W-1:0] out_re;
   logic [W-1:0] out_im;
   logic         out_valid;
   logic         out_sof;
   logic         out_ready;
   logic         frame_err;

   hilbert_spectral_mask #(.N(N), .W(W)) dut (
      .clk(clk), .rst(rst),
      .in_re(in_re), .in_im(in_im), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
      .mode(mode),
      .out_re(out_re), .out_im(out_im), .out_valid(out_valid), .out_sof(out_sof), .out_ready(out_ready),
      .frame_err(frame_err)
   );

   int   cmp_n = 0;
   int   fail_n = 0;
   bin_t obs_q[$];
   bin_t exp_q[$];
   logic ferr_obs[$];
   logic ferr_exp[$];
   logic ferr_pend;
   bit   m_sync;
   int   m_k;
   logic m_mode;
   logic s_ov, s_or, s_ir, s_acc;
   bin_t s_data;
   int   cyc = 0;
   int   first_acc, first_out;

   int fr_re[4] = '{10, -2, -2, -2};
   int fr_im[4] = '{0, 2, 0, -2};
   int hx_re[4] = '{0, 2, 0, 2};
   int hx_im[4] = '{0, 2, 0, -2};
   int ax_re[4] = '{10, -4, -2, 0};
   int ax_im[4] = '{0, 4, 0, 0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] to_w(input longint v);
      return v[W-1:0];
   endfunction

   function automatic longint clamp(input longint v);
      if (v > LIM - 1) return LIM - 1;
      if (v < -LIM) return -LIM;
      return v;
   endfunction

   // Bin weighting straight from the rules: multiply by -j / +j / 2 / 0, then clip.
   function automatic bin_t ref_bin(input logic md, input int k, input logic [W-1:0] re, input logic [W-1:0] im);
      bin_t   b;
      longint r, i, orv, oiv;
      r = longint'($signed(re));
      i = longint'($signed(im));
      orv = 0;
      oiv = 0;
      if (k == 0 || k == N / 2) begin
         if (md) begin orv = r; oiv = i; end
      end else if (k < N / 2) begin
         if (md) begin orv = 2 * r; oiv = 2 * i; end
         else begin orv = i; oiv = -r; end
      end else if (!md) begin
         orv = -i; oiv = r;
      end
      b.sof = (k == 0);
      b.re  = to_w(clamp(orv));
      b.im  = to_w(clamp(oiv));
      return b;
   endfunction

   function automatic longint rnd_val();
      logic [W-1:0] v;
      v = W'($urandom);
      case ($urandom_range(0, 7))
         0: return LIM - 1;
         1: return -LIM;
         2: return LIM / 2;
         3: return -(LIM / 2) - 1;
         default: return longint'($signed(v));
      endcase
   endfunction

   task automatic model_accept(input logic sof, input logic md, input logic [W-1:0] re, input logic [W-1:0] im);
      if (sof) begin
         if (m_sync && m_k != 0) ferr_pend = 1'b1;
         m_sync = 1'b1;
         m_k    = 0;
         m_mode = md;
      end
      if (m_sync) begin
         exp_q.push_back(ref_bin(m_mode, m_k, re, im));
         m_k = (m_k + 1) % N;
      end
   endtask

   task automatic clear_q();
      obs_q.delete(); exp_q.delete(); ferr_obs.delete(); ferr_exp.delete();
   endtask

   task automatic clear_all();
      clear_q();
      ferr_pend = 1'b0;
      m_sync = 1'b0;
      m_k = 0;
      m_mode = 1'b0;
   endtask

   // Inputs are driven at the falling edge; everything is sampled 1 ns later.
   task automatic tick();
      #1;
      s_ov = out_valid;
      s_or = out_ready;
      s_ir = in_ready;
      s_data.sof = out_sof;
      s_data.re  = out_re;
      s_data.im  = out_im;
      s_acc = in_valid && in_ready;
      ferr_obs.push_back(frame_err);
      ferr_exp.push_back(ferr_pend);
      ferr_pend = 1'b0;
      if (out_valid && out_ready) obs_q.push_back(s_data);
      if (s_acc) model_accept(in_sof, mode, in_re, in_im);
      if (s_acc && first_acc < 0) first_acc = cyc;
      if (s_ov && first_out < 0) first_out = cyc;
      cyc++;
      @(negedge clk);
   endtask

   task automatic send(input logic sof, input logic md, input longint re, input longint im);
      int budget;
      in_valid = 1'b1; in_sof = sof; mode = md; in_re = to_w(re); in_im = to_w(im);
      budget = 0;
      do begin
         tick();
         budget++;
      end while (!s_acc && budget < 20);
      cmp_n++;
      if (!s_acc) begin fail_n++; $display("FAIL send_timeout got no accept exp accept within 20 cycles"); end
      in_valid = 1'b0; in_sof = 1'b0;
   endtask

   task automatic drain();
      in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (!s_ov && obs_q.size() >= exp_q.size()) break;
      end
   endtask

   task automatic apply_reset();
      in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      clear_all();
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0; mode = 1'b0;
      in_re = '0; in_im = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      cmp_n++;
      if ({out_valid, out_sof, frame_err} !== 3'b000) begin
         fail_n++; $display("FAIL reset_flags got %b exp 000", {out_valid, out_sof, frame_err});
      end
      cmp_n++;
      if (out_re !== '0 || out_im !== '0) begin
         fail_n++; $display("FAIL reset_data got %h/%h exp 0/0", out_re, out_im);
      end
      @(negedge clk);
      rst = 1'b1;
      clear_all();
      tick();
      tick();
      cmp_n++;
      if (s_ir !== 1'b1) begin fail_n++; $display("FAIL reset_in_ready got %b exp 1", s_ir); end
   endtask

   task automatic test_hilb();
      bin_t e;
      clear_q(); first_acc = -1; first_out = -1;
      for (int j = 0; j < N; j++) send(j == 0, 1'b0, longint'(fr_re[j] * Q), longint'(fr_im[j] * Q));
      drain();
      cmp_n++;
      if (obs_q.size() != N) begin fail_n++; $display("FAIL hilb_count got %0d exp %0d", obs_q.size(), N); end
      for (int j = 0; j < N && j < obs_q.size(); j++) begin
         e.sof = (j == 0); e.re = to_w(longint'(hx_re[j] * Q)); e.im = to_w(longint'(hx_im[j] * Q));
         cmp_n++;
         if (obs_q[j] !== e) begin fail_n++; $display("FAIL hilb_bin%0d got %h exp %h", j, obs_q[j], e); end
      end
      cmp_n++;
      if (first_out - first_acc !== 2) begin
         fail_n++; $display("FAIL hilb_latency got %0d exp 2", first_out - first_acc);
      end
   endtask

   task automatic test_ana();
      bin_t e;
      clear_q();
      // mode drops to 0 after SOF; the frame must stay ANA
      for (int j = 0; j < N; j++) send(j == 0, j == 0, longint'(fr_re[j] * Q), longint'(fr_im[j] * Q));
      drain();
      cmp_n++;
      if (obs_q.size() != N) begin fail_n++; $display("FAIL ana_count got %0d exp %0d", obs_q.size(), N); end
      for (int j = 0; j < N && j < obs_q.size(); j++) begin
         e.sof = (j == 0); e.re = to_w(longint'(ax_re[j] * Q)); e.im = to_w(longint'(ax_im[j] * Q));
         cmp_n++;
         if (obs_q[j] !== e) begin fail_n++; $display("FAIL ana_bin%0d got %h exp %h", j, obs_q[j], e); end
      end
   endtask

   task automatic test_saturation();
      clear_q();
      send(1'b1, 1'b1, 0, 0);
      send(1'b0, 1'b1, 'h0FFFFF, -'h100000);
      send(1'b0, 1'b1, 0, 0);
      send(1'b0, 1'b1, 0, 0);
      send(1'b1, 1'b0, 0, 0);
      send(1'b0, 1'b0, -'h100000, 0);
      send(1'b0, 1'b0, 0, 0);
      send(1'b0, 1'b0, 0, -'h100000);
      drain();
      cmp_n++;
      if (obs_q.size() != 2 * N) begin fail_n++; $display("FAIL sat_count got %0d exp %0d", obs_q.size(), 2 * N); end
      if (obs_q.size() == 2 * N) begin
         cmp_n++;
         if (obs_q[1].re !== 21'h0FFFFF || obs_q[1].im !== 21'h100000) begin
            fail_n++; $display("FAIL sat_ana_dbl got %h/%h exp 0fffff/100000", obs_q[1].re, obs_q[1].im);
         end
         cmp_n++;
         if (obs_q[5].re !== 21'h0 || obs_q[5].im !== 21'h0FFFFF) begin
            fail_n++; $display("FAIL sat_hilb_neg1 got %h/%h exp 000000/0fffff", obs_q[5].re, obs_q[5].im);
         end
         cmp_n++;
         if (obs_q[7].re !== 21'h0FFFFF || obs_q[7].im !== 21'h0) begin
            fail_n++; $display("FAIL sat_hilb_neg3 got %h/%h exp 0fffff/000000", obs_q[7].re, obs_q[7].im);
         end
      end
   endtask

   task automatic test_sync();
      int ones;
      apply_reset();
      for (int j = 0; j < 3; j++) send(1'b0, 1'b0, rnd_val(), rnd_val());
      drain();
      cmp_n++;
      if (obs_q.size() != 0) begin fail_n++; $display("FAIL sync_discard got %0d exp 0", obs_q.size()); end
      send(1'b1, 1'b0, rnd_val(), rnd_val());
      send(1'b0, 1'b0, rnd_val(), rnd_val());
      send(1'b1, 1'b1, 3 * Q, -5 * Q);
      for (int j = 1; j < N; j++) send(1'b0, 1'b0, rnd_val(), rnd_val());
      drain();
      cmp_n++;
      if (obs_q.size() != N + 2) begin fail_n++; $display("FAIL sync_count got %0d exp %0d", obs_q.size(), N + 2); end
      if (obs_q.size() > 2) begin
         cmp_n++;
         if (obs_q[2].sof !== 1'b1 || obs_q[2].re !== to_w(3 * Q) || obs_q[2].im !== to_w(-5 * Q)) begin
            fail_n++; $display("FAIL sync_resof got %h exp sof=1 ana pass-through", obs_q[2]);
         end
      end
      for (int j = 0; j < obs_q.size() && j < exp_q.size(); j++) begin
         cmp_n++;
         if (obs_q[j] !== exp_q[j]) begin fail_n++; $display("FAIL sync_bin%0d got %h exp %h", j, obs_q[j], exp_q[j]); end
      end
      ones = 0;
      foreach (ferr_obs[i]) if (ferr_obs[i] === 1'b1) ones++;
      cmp_n++;
      if (ones != 1) begin fail_n++; $display("FAIL sync_ferr_pulses got %0d exp 1", ones); end
      for (int i = 0; i < ferr_obs.size(); i++) begin
         cmp_n++;
         if (ferr_obs[i] !== ferr_exp[i]) begin
            fail_n++; $display("FAIL sync_ferr_cycle%0d got %b exp %b", i, ferr_obs[i], ferr_exp[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int accs;
      clear_q(); out_ready = 1'b1; accs = 0;
      for (int j = 0; j < 2 * N; j++) begin
         in_valid = 1'b1; in_sof = (j % N == 0); mode = 1'($urandom_range(0, 1));
         in_re = to_w(rnd_val()); in_im = to_w(rnd_val());
         tick();
         if (s_acc) accs++;
      end
      drain();
      cmp_n++;
      if (accs != 2 * N) begin fail_n++; $display("FAIL b2b_accepts got %0d exp %0d", accs, 2 * N); end
      cmp_n++;
      if (obs_q.size() != exp_q.size()) begin fail_n++; $display("FAIL b2b_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
      for (int j = 0; j < obs_q.size() && j < exp_q.size(); j++) begin
         cmp_n++;
         if (obs_q[j] !== exp_q[j]) begin fail_n++; $display("FAIL b2b_bin%0d got %h exp %h", j, obs_q[j], exp_q[j]); end
      end
   endtask

   task automatic test_stall_hold();
      longint hr[4], hi[4];
      int     j, accs;
      bin_t   held;
      clear_q(); out_ready = 1'b0; j = 0; accs = 0; held = '0;
      for (int i = 0; i < N; i++) begin hr[i] = rnd_val(); hi[i] = rnd_val(); end
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1; in_sof = (j == 0); mode = 1'b0; in_re = to_w(hr[j]); in_im = to_w(hi[j]);
         tick();
         if (s_acc) begin j++; accs++; end
         if (c == 2) held = s_data;
         if (c > 2) begin
            cmp_n++;
            if (s_ov !== 1'b1 || s_data !== held) begin
               fail_n++; $display("FAIL hold_stable c%0d got %b/%h exp 1/%h", c, s_ov, s_data, held);
            end
         end
      end
      cmp_n++;
      if (accs != 2) begin fail_n++; $display("FAIL hold_accepts got %0d exp 2", accs); end
      cmp_n++;
      if (s_ir !== 1'b0) begin fail_n++; $display("FAIL hold_in_ready got %b exp 0", s_ir); end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = j; i < N; i++) send(1'b0, 1'b0, hr[i], hi[i]);
      drain();
      cmp_n++;
      if (obs_q.size() != N) begin fail_n++; $display("FAIL hold_count got %0d exp %0d", obs_q.size(), N); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         cmp_n++;
         if (obs_q[i] !== exp_q[i]) begin fail_n++; $display("FAIL hold_bin%0d got %h exp %h", i, obs_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_backpressure();
      int     beat, total, budget;
      logic   b_sof, b_md, pstall;
      longint b_re, b_im;
      bin_t   pdata;
      clear_q();
      total = 64 * N; beat = 0; budget = 0; pstall = 1'b0; pdata = '0;
      b_sof = 1'b1; b_md = 1'($urandom_range(0, 1)); b_re = rnd_val(); b_im = rnd_val();
      while (beat < total && budget < 4000) begin
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = 1'($urandom_range(0, 1));
         in_sof = b_sof; mode = b_md; in_re = to_w(b_re); in_im = to_w(b_im);
         tick();
         budget++;
         if (pstall) begin
            cmp_n++;
            if (s_ov !== 1'b1 || s_data !== pdata) begin
               fail_n++; $display("FAIL bp_stable cyc%0d got %b/%h exp 1/%h", cyc, s_ov, s_data, pdata);
            end
         end
         pstall = s_ov && !s_or;
         pdata = s_data;
         if (s_acc) begin
            beat++;
            b_sof = (beat % N == 0) || ($urandom_range(0, 31) == 0);
            b_md = 1'($urandom_range(0, 1)); b_re = rnd_val(); b_im = rnd_val();
         end
      end
      cmp_n++;
      if (beat < total) begin fail_n++; $display("FAIL bp_timeout got %0d beats exp %0d", beat, total); end
      drain();
      cmp_n++;
      if (obs_q.size() != exp_q.size()) begin fail_n++; $display("FAIL bp_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
      for (int j = 0; j < obs_q.size() && j < exp_q.size(); j++) begin
         cmp_n++;
         if (obs_q[j] !== exp_q[j]) begin fail_n++; $display("FAIL bp_bin%0d got %h exp %h", j, obs_q[j], exp_q[j]); end
      end
      for (int i = 0; i < ferr_obs.size(); i++) begin
         cmp_n++;
         if (ferr_obs[i] !== ferr_exp[i]) begin
            fail_n++; $display("FAIL bp_ferr_cycle%0d got %b exp %b", i, ferr_obs[i], ferr_exp[i]);
         end
      end
   endtask

   task automatic test_reset_stall();
      clear_q(); out_ready = 1'b0;
      send(1'b1, 1'b1, rnd_val(), rnd_val());
      send(1'b0, 1'b1, rnd_val(), rnd_val());
      cmp_n++;
      if (out_valid !== 1'b1) begin fail_n++; $display("FAIL rst_stall_pre got %b exp 1", out_valid); end
      #2 rst = 1'b0;
      #1;
      cmp_n++;
      if ({out_valid, out_sof, frame_err} !== 3'b000 || out_re !== '0 || out_im !== '0) begin
         fail_n++; $display("FAIL rst_stall_outs got %b %h/%h exp 000 0/0", {out_valid, out_sof, frame_err}, out_re, out_im);
      end
      @(negedge clk);
      rst = 1'b1;
      clear_all();
      out_ready = 1'b1;
      tick();
      tick();
      cmp_n++;
      if (s_ir !== 1'b1 || s_ov !== 1'b0) begin
         fail_n++; $display("FAIL rst_stall_release got ir=%b ov=%b exp ir=1 ov=0", s_ir, s_ov);
      end
      send(1'b0, 1'b1, rnd_val(), rnd_val());
      for (int j = 0; j < N; j++) send(j == 0, 1'b0, rnd_val(), rnd_val());
      drain();
      cmp_n++;
      if (obs_q.size() != N) begin fail_n++; $display("FAIL rst_stall_count got %0d exp %0d", obs_q.size(), N); end
      for (int j = 0; j < obs_q.size() && j < exp_q.size(); j++) begin
         cmp_n++;
         if (obs_q[j] !== exp_q[j]) begin fail_n++; $display("FAIL rst_stall_bin%0d got %h exp %h", j, obs_q[j], exp_q[j]); end
      end
   endtask

   initial begin
      first_acc = -1;
      first_out = -1;
      test_reset();
      test_hilb();
      test_ana();
      test_saturation();
      test_sync();
      test_back_to_back();
      test_stall_hold();
      test_backpressure();
      test_reset_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got no completion exp finish before 1 ms");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/hilbert_spectral_mask.md
# hilbert_spectral_mask

- Streaming frequency-domain stage directly downstream of the `FFT` block in the Hilbert-transform datapath.
- Consumes one complex bin per accepted beat: `outr`/`outi`, 21-bit Q10.10 signed.
- Applies the Hilbert spectral weighting by bin index, or the analytic-signal weighting when selected, and forwards the result to the IFFT stage through a valid/ready handshake.
- Multiplier-free: uses only swap, negate, shift and saturate.

## Interface
- `N`, 4 — bins per frame; power of two, ≥4.
- `W`, 21 — sample width: sign + 10 integer + 10 fraction bits.
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `in_re`, `in_im`  in  W  — FFT bin, real/imag.
- `in_valid`  in  1  — bin present.
- `in_sof`  in  1  — marks bin 0 of a frame; qualified by `in_valid`.
- `in_ready`  out  1  — stage can accept.
- `mode`  in  1  — 0 = Hilbert spectrum (HILB), 1 = analytic spectrum (ANA); sampled only on an accepted SOF beat.
- `out_re`, `out_im`  out  W  — weighted bin.
- `out_valid`  out  1  — output bin present.
- `out_sof`  out  1  — output bin is bin 0.
- `out_ready`  in  1  — downstream accepts.
- `frame_err`  out  1  — one-cycle pulse on an SOF misalignment.

## Operation
- Accept: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- FSM, two states:
  - **UNSYNC** (reset state): `in_ready`=1; all non-SOF beats are discarded. An accepted SOF beat moves to SYNC, is processed as bin k=0, and latches `mode`.
  - **SYNC**: bin counter k increments on every accepted beat and wraps from N-1 to 0.
- SOF misalignment in SYNC: an accepted SOF beat arriving while k≠0 pulses `frame_err` for one cycle, forces k=0, processes the beat as bin 0, and re-latches `mode`. The FSM stays in SYNC.
- HILB weighting:
  - k=0 or k=N/2: output (0, 0).
  - 1≤k<N/2: multiply by -j, giving (im, -re).
  - N/2<k<N: multiply by +j, giving (-im, re).
- ANA weighting:
  - k=0 or k=N/2: pass through unchanged.
  - 1≤k<N/2: multiply by 2 with saturation.
  - N/2<k<N: output (0, 0).
- Saturation limits: +2^(W-1)-1 and -2^(W-1).
  - Negating -2^(W-1) yields 2^(W-1)-1.
  - Doubling clips to these limits.
  - No other rounding is performed.
- `out_sof` is 1 exactly when the output bin index is 0.

## Timing
- Two-stage elastic pipeline:
  - S1 registers the data, k, sof and mode.
  - S2 registers the weighted, saturated result.
- Latency: 2 cycles from acceptance to `out_valid`, with no backpressure. Sustained throughput is 1 bin/cycle.
- Each stage loads when it is empty or its contents move on in the same cycle.
- `in_ready` = !S1_full || S1 advancing. It is combinational from `out_ready` through S2.
- While `out_valid`=1 and `out_ready`=0:
  - `out_re`, `out_im`, `out_sof` hold stable.
  - At most 2 bins are buffered.
  - No bin is dropped or duplicated.
- `mode` is frame-constant: a change that does not coincide with an accepted SOF beat takes effect at the next accepted SOF.
- Reset (asynchronous assert, any cycle, including mid-frame or mid-stall):
  - FSM returns to UNSYNC, k=0, both stages empty.
  - `out_valid`=0, `out_re`=0, `out_im`=0, `out_sof`=0, `frame_err`=0, latched mode=0.
  - `in_ready` is 1 one cycle after release.
- `frame_err` is registered: it asserts the cycle after the offending acceptance, independent of `out_ready`.

## Test plan
- **HILB, N=4, no backpressure.** Frame (10,0), (-2,2), (-2,0), (-2,-2), scaled ×1024 (Q10.10), SOF on the first beat, `mode`=0.
  - Required output: (0,0), (2,2), (0,0), (2,-2), each ×1024.
  - `out_sof` on the first output; first output 2 cycles after first accept.
- **ANA, same frame, `mode`=1.**
  - Required output: (10,0), (-4,4), (-2,0), (0,0), each ×1024.
- **Saturation.** Bin 1, ANA, re=0x0FFFFF, im=0x100000.
  - Required output: re=0x0FFFFF, im=0x100000 (both clipped).
  - Same bin in HILB with re=0x100000 gives out_im=0x0FFFFF.
- **Sync and misalignment.**
  - Three non-SOF beats after reset produce no output.
  - Then SOF begins the frame. A second SOF at k=2 produces a `frame_err` pulse, and that beat is emitted as bin 0 with `out_sof`=1.
- **Backpressure.**
  - Random `out_ready` (50%) over 64 frames; the output sequence must equal the reference model exactly.
  - Holding `out_ready`=0 for 5 cycles: `in_ready` drops after 2 accepts, and outputs stay stable.
- **Reset mid-stall.**
  - Assert `rst`=0 with 2 bins buffered: `out_valid`=0 immediately.
  - After release, the block is in UNSYNC; the next frame produces correct output starting at SOF.
